// File: rtl/uart_vga_writer_pkg.sv
// Shared definitions for the UART-to-VGA text console writer: FSM states,
// control codes and the default character-grid geometry.
package uart_vga_writer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CLR_ROW = 2'd1,
        CLR_ALL = 2'd2
    } state_t;

    // Control codes interpreted by the writer
    localparam logic [7:0] LF = 8'h0A;
    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] BS = 8'h08;
    localparam logic [7:0] FF = 8'h0C;

    // Character grid geometry and fill character
    localparam int         COLS  = 20;
    localparam int         ROWS  = 64;
    localparam logic [7:0] BLANK = 8'h20;

endpackage

// File: rtl/uart_vga_writer.sv
// Text-console writer: turns received bytes into character writes for the
// VGA text RAM, tracks a cursor, and clears rows or the whole screen with
// one RAM write per cycle.
module uart_vga_writer
    import uart_vga_writer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] write_address,
    output logic [7:0]  ram_in,
    output logic        we,
    output logic [4:0]  cursor_col,
    output logic [5:0]  cursor_row,
    output logic        busy
);

    state_t      state_q, state_d;
    logic [4:0]  col_q, col_d;
    logic [5:0]  row_q, row_d;
    logic [10:0] clr_idx_q, clr_idx_d;
    logic        we_q, we_d;
    logic [10:0] addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic        busy_q, busy_d;

    // Write request assembled by the FSM; address is wr_row*COLS + wr_off
    logic        wr_en;
    logic [5:0]  wr_row;
    logic [10:0] wr_off;
    logic [7:0]  wr_data;
    logic        clr_issue;
    logic        accept;
    logic [5:0]  row_inc;

    assign in_ready = (state_q == IDLE) && !rst;
    assign accept   = in_valid && in_ready;

    // Row advance wraps explicitly at the last row (no scrolling)
    assign row_inc = (row_q == 6'(ROWS - 1)) ? 6'd0 : row_q + 6'd1;

    // Next-state, cursor update and write-request decode
    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        clr_idx_d = clr_idx_q;
        wr_en     = 1'b0;
        wr_row    = row_q;
        wr_off    = 11'd0;
        wr_data   = BLANK;
        clr_issue = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (in_data >= 8'h20 && in_data <= 8'h7E) begin
                        wr_en   = 1'b1;
                        wr_data = in_data;
                        wr_off  = 11'(col_q);
                        if (col_q == 5'(COLS - 1)) begin
                            // Own write goes out first; the row clear follows from index 0
                            col_d     = 5'd0;
                            row_d     = row_inc;
                            state_d   = CLR_ROW;
                            clr_idx_d = 11'd0;
                        end else begin
                            col_d = col_q + 5'd1;
                        end
                    end else begin
                        case (in_data)
                            LF: begin
                                // No character of its own, so the first blank is written right away
                                col_d     = 5'd0;
                                row_d     = row_inc;
                                state_d   = CLR_ROW;
                                wr_en     = 1'b1;
                                wr_row    = row_inc;
                                wr_off    = 11'd0;
                                clr_issue = 1'b1;
                                clr_idx_d = 11'd1;
                            end
                            CR: begin
                                col_d = 5'd0;
                            end
                            BS: begin
                                if (col_q != 5'd0) begin
                                    col_d  = col_q - 5'd1;
                                    wr_en  = 1'b1;
                                    wr_off = 11'(col_q - 5'd1);
                                end
                            end
                            FF: begin
                                state_d   = CLR_ALL;
                                wr_en     = 1'b1;
                                wr_row    = 6'd0;
                                wr_off    = 11'd0;
                                clr_issue = 1'b1;
                                clr_idx_d = 11'd1;
                            end
                            default: begin
                            end
                        endcase
                    end
                end
            end

            CLR_ROW: begin
                wr_en     = 1'b1;
                wr_off    = clr_idx_q;
                clr_issue = 1'b1;
                if (clr_idx_q == 11'(COLS - 1)) begin
                    state_d   = IDLE;
                    clr_idx_d = 11'd0;
                end else begin
                    clr_idx_d = clr_idx_q + 11'd1;
                end
            end

            CLR_ALL: begin
                // Row 0 base plus a linear index sweeps the whole RAM
                wr_en     = 1'b1;
                wr_row    = 6'd0;
                wr_off    = clr_idx_q;
                clr_issue = 1'b1;
                if (clr_idx_q == 11'(COLS * ROWS - 1)) begin
                    state_d   = IDLE;
                    clr_idx_d = 11'd0;
                    col_d     = 5'd0;
                    row_d     = 6'd0;
                end else begin
                    clr_idx_d = clr_idx_q + 11'd1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Registered write port values; address/data hold when no write is issued
    always_comb begin
        we_d   = wr_en;
        addr_d = wr_en ? (11'(wr_row) * 11'(COLS) + wr_off) : addr_q;
        data_d = wr_en ? wr_data : data_q;
        busy_d = (state_d != IDLE) || clr_issue;
    end

    // State, cursor and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            col_q     <= 5'd0;
            row_q     <= 6'd0;
            clr_idx_q <= 11'd0;
            we_q      <= 1'b0;
            addr_q    <= 11'd0;
            data_q    <= 8'd0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            clr_idx_q <= clr_idx_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            busy_q    <= busy_d;
        end
    end

    assign write_address = {21'd0, addr_q};
    assign ram_in        = data_q;
    assign we            = we_q;
    assign cursor_col    = col_q;
    assign cursor_row    = row_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_uart_vga_writer.sv
// Directed self-checking bench for uart_vga_writer.
module tb_uart_vga_writer;

    logic        clk;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] write_address;
    logic [7:0]  ram_in;
    logic        we;
    logic [4:0]  cursor_col;
    logic [5:0]  cursor_row;
    logic        busy;

    int tests_run;
    int tests_failed;

    uart_vga_writer dut (
        .clk           (clk),
        .rst           (rst),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .write_address (write_address),
        .ram_in        (ram_in),
        .we            (we),
        .cursor_col    (cursor_col),
        .cursor_row    (cursor_row),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for in_ready at a falling edge, presents one byte for a
    // single rising edge, and returns at the falling edge of the cycle after
    // acceptance, where that byte's write (if any) is visible.
    task automatic send(input logic [7:0] b);
        int t;
        t = 0;
        while (!in_ready && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) chk("send_ready_timeout", {31'd0, in_ready}, 32'd1);
        $display("[TB] send byte 0x%02h at %0t", b, $time);
        in_data  = b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    // Observes n cycles expecting consecutive BLANK writes from base upward
    task automatic run_blanks(input int base, input int n,
                              output int good, output int low_rdy, output int busy_hi);
        good    = 0;
        low_rdy = 0;
        busy_hi = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (we === 1'b1 && write_address === 32'(base + i) && ram_in === 8'h20) good++;
            if (in_ready !== 1'b1) low_rdy++;
            if (busy === 1'b1) busy_hi++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int good;
        int low_rdy;
        int busy_hi;

        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        in_valid     = 1'b0;
        in_data      = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_we", {31'd0, we}, 32'd0);
        chk("rst_addr", write_address, 32'd0);
        chk("rst_ram_in", {24'd0, ram_in}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_cursor", {21'd0, cursor_row, cursor_col}, 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_release_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);

        // Plain text, back-to-back
        send(8'h41);
        chk("A_we", {31'd0, we}, 32'd1);
        chk("A_addr", write_address, 32'd0);
        chk("A_data", {24'd0, ram_in}, 32'h41);
        send(8'h42);
        chk("B_we", {31'd0, we}, 32'd1);
        chk("B_addr", write_address, 32'd1);
        chk("B_data", {24'd0, ram_in}, 32'h42);
        chk("AB_cursor_col", {27'd0, cursor_col}, 32'd2);
        chk("AB_cursor_row", {26'd0, cursor_row}, 32'd0);
        @(negedge clk);
        chk("AB_idle_we", {31'd0, we}, 32'd0);

        // Column wrap
        do_reset();
        for (int i = 0; i < 20; i++) send(8'h78);
        chk("wrap_last_addr", write_address, 32'd19);
        chk("wrap_last_data", {24'd0, ram_in}, 32'h78);
        chk("wrap_cursor", {21'd0, cursor_row, cursor_col}, {21'd0, 6'd1, 5'd0});
        chk("wrap_ready_low", {31'd0, in_ready}, 32'd0);
        chk("wrap_busy", {31'd0, busy}, 32'd1);
        run_blanks(20, 20, good, low_rdy, busy_hi);
        chk("wrap_clear_writes", good, 32'd20);
        chk("wrap_ready_low_cycles", low_rdy + 1, 32'd20);
        @(negedge clk);
        chk("wrap_done_we", {31'd0, we}, 32'd0);
        chk("wrap_done_busy", {31'd0, busy}, 32'd0);

        // Control codes
        do_reset();
        send(8'h51);
        chk("Q_addr", write_address, 32'd0);
        chk("Q_data", {24'd0, ram_in}, 32'h51);
        send(8'h08);
        chk("BS_we", {31'd0, we}, 32'd1);
        chk("BS_addr", write_address, 32'd0);
        chk("BS_data", {24'd0, ram_in}, 32'h20);
        chk("BS_cursor", {21'd0, cursor_row, cursor_col}, 32'd0);
        send(8'h08);
        chk("BS_col0_we", {31'd0, we}, 32'd0);
        chk("BS_col0_cursor", {21'd0, cursor_row, cursor_col}, 32'd0);
        send(8'h0D);
        chk("CR_we", {31'd0, we}, 32'd0);
        chk("CR_cursor", {21'd0, cursor_row, cursor_col}, 32'd0);
        send(8'h0A);
        chk("LF_first_we", {31'd0, we}, 32'd1);
        chk("LF_first_addr", write_address, 32'd20);
        chk("LF_first_data", {24'd0, ram_in}, 32'h20);
        chk("LF_cursor", {21'd0, cursor_row, cursor_col}, {21'd0, 6'd1, 5'd0});
        run_blanks(21, 19, good, low_rdy, busy_hi);
        chk("LF_clear_writes", good, 32'd19);
        @(negedge clk);
        chk("LF_done_we", {31'd0, we}, 32'd0);
        send(8'h07);
        chk("BEL_we", {31'd0, we}, 32'd0);
        chk("BEL_cursor", {21'd0, cursor_row, cursor_col}, {21'd0, 6'd1, 5'd0});

        // Row wrap
        do_reset();
        for (int i = 0; i < 63; i++) send(8'h0A);
        chk("row63_cursor", {21'd0, cursor_row, cursor_col}, {21'd0, 6'd63, 5'd0});
        send(8'h0A);
        chk("rowwrap_cursor", {21'd0, cursor_row, cursor_col}, 32'd0);
        chk("rowwrap_first_addr", write_address, 32'd0);
        chk("rowwrap_first_we", {31'd0, we}, 32'd1);
        run_blanks(1, 19, good, low_rdy, busy_hi);
        chk("rowwrap_clear_writes", good, 32'd19);

        // Screen clear
        send(8'h5A);
        send(8'h5A);
        chk("pre_ff_cursor", {21'd0, cursor_row, cursor_col}, {21'd0, 6'd0, 5'd2});
        send(8'h0C);
        chk("FF_first_addr", write_address, 32'd0);
        chk("FF_first_data", {24'd0, ram_in}, 32'h20);
        chk("FF_first_busy", {31'd0, busy}, 32'd1);
        run_blanks(1, 1279, good, low_rdy, busy_hi);
        chk("FF_clear_writes", good, 32'd1279);
        chk("FF_busy_cycles", busy_hi + 1, 32'd1280);
        @(negedge clk);
        chk("FF_done_busy", {31'd0, busy}, 32'd0);
        chk("FF_done_we", {31'd0, we}, 32'd0);
        chk("FF_done_cursor", {21'd0, cursor_row, cursor_col}, 32'd0);
        chk("FF_done_ready", {31'd0, in_ready}, 32'd1);

        // Reset mid-clear
        send(8'h4B);
        chk("K_cursor", {21'd0, cursor_row, cursor_col}, {21'd0, 6'd0, 5'd1});
        send(8'h0C);
        repeat (500) @(negedge clk);
        chk("midclr_addr", write_address, 32'd500);
        chk("midclr_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("midclr_rst_we", {31'd0, we}, 32'd0);
        chk("midclr_rst_cursor", {21'd0, cursor_row, cursor_col}, 32'd0);
        chk("midclr_rst_busy", {31'd0, busy}, 32'd0);
        chk("midclr_rst_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b0;
        #1;
        chk("midclr_release_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        chk("midclr_after_we", {31'd0, we}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
